// File: rtl/midi_pkg.sv
// Shared MIDI definitions: transmitter states, frame constants and NBits legalisation.
package midi_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int TICKS_PER_BIT_DEF = 16;
    localparam int MIDI_BAUD         = 31250;

    localparam logic [3:0] NBITS_8 = 4'd8;
    localparam logic [3:0] NBITS_7 = 4'd7;
    localparam logic [3:0] NBITS_6 = 4'd6;

    // Anything other than 7 or 6 falls back to a full 8-bit frame.
    function automatic logic [3:0] eff_nbits(input logic [3:0] n);
        return (n == NBITS_7 || n == NBITS_6) ? n : NBITS_8;
    endfunction

endpackage

// File: rtl/midi_tx_fifo.sv
// Byte FIFO for the MIDI transmitter; show-ahead head, write accepted on full when popping.
module midi_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     wr,
    input  logic [7:0]               wr_data,
    input  logic                     rd,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_rd   = rd && !empty;
    assign do_wr   = wr && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/midi_tx.sv
// MIDI/UART serial transmitter: FIFO-fed, start + NBits LSB-first + stop, paced by the 16x Tick.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte with TxEn
//   START | start bit (low)
//   DATA  | data bits, LSB first
//   STOP  | stop bit (high); may chain straight into the next START
module midi_tx
    import midi_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Tick,
    input  logic       TxEn,
    input  logic [3:0] NBits,
    input  logic       WrEn,
    input  logic [7:0] TxData,
    output logic       Tx,
    output logic       TxBusy,
    output logic       TxDone,
    output logic       Full,
    output logic       Empty,
    output logic       Overflow
);
    localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    tx_state_t       state, state_nx;
    logic [3:0]      tick_cnt, tick_cnt_nx;
    logic [3:0]      bit_idx, bit_idx_nx;
    logic [3:0]      nbits_q, nbits_nx;
    logic [7:0]      shift_q, shift_nx;
    logic [7:0]      head;
    logic [CW-1:0]   fifo_count;
    logic            pop;
    logic            bit_end;
    logic            tx_nx;
    logic            done_nx;

    midi_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .wr      (WrEn),
        .wr_data (TxData),
        .rd      (pop),
        .rd_data (head),
        .full    (Full),
        .empty   (Empty),
        .count   (fifo_count)
    );

    assign bit_end = Tick && (tick_cnt == TICK_LAST);
    assign TxBusy  = (state != IDLE);

    always_comb begin
        state_nx    = state;
        tick_cnt_nx = tick_cnt;
        bit_idx_nx  = bit_idx;
        nbits_nx    = nbits_q;
        shift_nx    = shift_q;
        pop         = 1'b0;
        done_nx     = 1'b0;
        if (Tick) begin
            case (state)
                IDLE:  pop = !Empty && TxEn;
                START: begin
                    tick_cnt_nx = tick_cnt + 1'b1;
                    if (bit_end) begin
                        tick_cnt_nx = '0;
                        bit_idx_nx  = '0;
                        state_nx    = DATA;
                    end
                end
                DATA: begin
                    tick_cnt_nx = tick_cnt + 1'b1;
                    if (bit_end) begin
                        tick_cnt_nx = '0;
                        shift_nx    = shift_q >> 1;
                        bit_idx_nx  = bit_idx + 1'b1;
                        if (bit_idx + 1'b1 == nbits_q) state_nx = STOP;
                    end
                end
                STOP: begin
                    tick_cnt_nx = tick_cnt + 1'b1;
                    if (bit_end) begin
                        tick_cnt_nx = '0;
                        done_nx     = 1'b1;
                        state_nx    = IDLE;
                        pop         = !Empty && TxEn;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        // Shared frame load: from IDLE or chained off the final stop tick.
        if (pop) begin
            shift_nx    = head;
            nbits_nx    = eff_nbits(NBits);
            tick_cnt_nx = '0;
            state_nx    = START;
        end
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            default: tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            nbits_q  <= NBITS_8;
            shift_q  <= '0;
            Tx       <= 1'b1;
            TxDone   <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            tick_cnt <= tick_cnt_nx;
            bit_idx  <= bit_idx_nx;
            nbits_q  <= nbits_nx;
            shift_q  <= shift_nx;
            Tx       <= tx_nx;
            TxDone   <= done_nx;
            Overflow <= WrEn && (fifo_count == CNT_FULL) && !pop;
        end
    end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- Serial MIDI/UART transmitter; the outbound counterpart of the synth's MIDI receiver.
- Accepts bytes from the note/controller logic into a small FIFO.
- Serialises each byte as one frame: start bit, NBits data bits LSB first, one stop bit.
- Uses the shared 16x-baud Tick strobe and drives the MIDI OUT/THRU line.

Parameters:
- FIFO_DEPTH, 4, byte entries buffered; power of two, 2..16.
- TICKS_PER_BIT, 16, Tick strobes per serial bit.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- Tick  in  1  one-Clk-cycle strobe at 16x baud, synchronous to Clk (31.25 kbaud x16 for MIDI).
- TxEn  in  1  transmit enable; gates the start of new frames only.
- NBits  in  4  data bits per frame; 8, 7 or 6 legal.
- WrEn  in  1  push TxData into the FIFO this Clk cycle.
- TxData  in  8  byte to send; bits [NBits-1:0] are transmitted.
- Tx  out  1  serial line; idle high.
- TxBusy  out  1  high while a frame is in progress (START/DATA/STOP).
- TxDone  out  1  one-Clk pulse at the end of each stop bit.
- Full  out  1  FIFO full.
- Empty  out  1  FIFO empty.
- Overflow  out  1  one-Clk pulse when WrEn is ignored because the FIFO is full.

Behaviour:
- Reset values: Tx=1, TxBusy=0, TxDone=0, Full=0, Empty=1, Overflow=0; FIFO pointers and count cleared; state IDLE.
- Reset mid-frame: Tx returns high immediately; the FIFO contents are discarded.
- Single clock domain. All registers clock on Clk. Tick is a clock enable, never a clock.
- FIFO write: WrEn && !Full stores TxData. WrEn && Full drops the byte and pulses Overflow.
- Simultaneous pop and write when Full: both happen; the write is accepted.
- Count width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- State machine advances only on cycles with Tick=1:
  - IDLE: if !Empty && TxEn, pop the head byte, latch it into the shift register, latch NBits (illegal values are treated as 8), clear the tick counter and go to START.
  - START: Tx=0 for TICKS_PER_BIT ticks, then go to DATA with bit index 0.
  - DATA: Tx = shift[0] for TICKS_PER_BIT ticks, then shift right and increment the index. When the index reaches latched NBits, go to STOP.
  - STOP: Tx=1 for TICKS_PER_BIT ticks. On the final tick pulse TxDone. If !Empty && TxEn, pop and go directly to START with no idle gap; else go to IDLE.
- Tx is registered and changes on the Clk cycle after the Tick that causes the transition.
- Latency: a byte written into an empty FIFO while idle drives Tx low on the cycle after the next Tick.
- The tick counter is 4 bits (TICKS_PER_BIT-1 terminal); the bit index is 4 bits.
- Changes to NBits mid-frame have no effect until the next frame.
- TxEn deasserted mid-frame: the current frame completes; no new frame starts.
- Frame length is (NBits+2)*TICKS_PER_BIT ticks: 160 for 8 bits, 144 for 7, 128 for 6.

Decomposition:
- Shared package midi_pkg holds:
  - tx state enum {IDLE, START, DATA, STOP};
  - TICKS_PER_BIT default;
  - legal NBits constants NBITS_8/7/6;
  - MIDI baud constant 31250.
- One sub-module, midi_tx_fifo: synchronous FIFO (parameter DEPTH, 8-bit data, wr/rd, full/empty/count, show-ahead head output).
- The serialiser FSM stays in midi_tx.

Test Plan:
- Reset: assert Rst_n=0 mid-frame -> Tx=1 in the same cycle, Empty=1, TxBusy=0; no TxDone.
- Single byte 0x90, NBits=8, TxEn=1 -> Tx per 16-tick bit: 0 (start), then 0,0,0,0,1,0,0,1, then 1 (stop); TxDone once after 160 ticks.
- Back-to-back 0x90, 0x3C, 0x7F written in consecutive cycles -> three contiguous frames, 480 ticks total, no idle tick between stop and next start; three TxDone pulses.
- NBits=7, byte 0x45 -> 9 bits: start, 1,0,1,0,0,0,1, stop; 144 ticks. NBits=4'd3 -> behaves as 8-bit (160 ticks).
- FIFO_DEPTH=4, TxEn=0, write 5 bytes -> Full after the 4th, Overflow pulse on the 5th. Raise TxEn -> exactly the first 4 bytes are sent in order.
- TxEn dropped during the DATA of the first of two queued bytes -> the first frame completes; Tx stays high; the second byte stays queued (Empty=0) until TxEn returns.
